// File: rtl/noc_sequencer.sv
// noc_sequencer: steps the router array through Init, routing-table load and repeated
// LoadStaging/Phase0/Phase1 rounds. Optional early termination: define SEQ_DONE_EARLY_EN.
module noc_sequencer #(
    parameter int ROUTER_SIZE = 4,
    parameter int ROUTER_BITS = 2,
    parameter int OP_SIZE     = 3,
    parameter int CYCLE_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [CYCLE_W-1:0]             max_cycle_i,
    input  logic [ROUTER_SIZE-1:0]         rt_valid_i,
    input  logic [ROUTER_SIZE-1:0]         router_done_i,
    input  logic                           stall_i,
    output logic [ROUTER_SIZE*OP_SIZE-1:0] op_o,
    output logic [ROUTER_BITS-1:0]         rt_dst_o,
    output logic [CYCLE_W-1:0]             in_cycle_o,
    output logic                           busy_o,
    output logic                           finished_o
);

    localparam logic [OP_SIZE-1:0] OP_NOP      = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_INIT     = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_LOAD_RT  = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_STAGING  = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_PHASE0   = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_PHASE1   = OP_SIZE'(5);
    localparam logic [ROUTER_BITS-1:0] LAST_DST = ROUTER_BITS'(ROUTER_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD_RT,
        S_STAGE,
        S_PH0,
        S_PH1,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ROUTER_BITS-1:0] rtDst_q, rtDst_d;
    logic [CYCLE_W-1:0]     inCycle_q, inCycle_d;
    logic [CYCLE_W-1:0]     maxCycle_q, maxCycle_d;
    logic [OP_SIZE-1:0]     op_q, op_d;
    logic                   busy_q, busy_d;
    logic                   finished_q, finished_d;
    logic                   earlyDone;

`ifdef SEQ_DONE_EARLY_EN
    assign earlyDone = &router_done_i;
`else
    logic unusedRouterDone;
    assign unusedRouterDone = ^router_done_i;
    assign earlyDone        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rtDst_q    <= '0;
            inCycle_q  <= '0;
            maxCycle_q <= '0;
            op_q       <= OP_NOP;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rtDst_q    <= rtDst_d;
            inCycle_q  <= inCycle_d;
            maxCycle_q <= maxCycle_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    // A stall in any busy state freezes state and counters so the held op is re-presented later.
    always_comb begin
        state_d    = state_q;
        rtDst_d    = rtDst_q;
        inCycle_d  = inCycle_q;
        maxCycle_d = maxCycle_q;
        if (state_q == S_IDLE || state_q == S_DONE) begin
            if (start_i) begin
                state_d    = S_INIT;
                rtDst_d    = '0;
                inCycle_d  = '0;
                maxCycle_d = max_cycle_i;
            end
        end else if (!stall_i) begin
            case (state_q)
                S_INIT:  state_d = S_LOAD_RT;
                S_LOAD_RT: begin
                    if (rtDst_q == LAST_DST) begin
                        rtDst_d = '0;
                        state_d = (maxCycle_q != '0) ? S_STAGE : S_DONE;
                    end else begin
                        rtDst_d = rtDst_q + ROUTER_BITS'(1);
                    end
                end
                S_STAGE: state_d = S_PH0;
                S_PH0:   state_d = S_PH1;
                S_PH1: begin
                    inCycle_d = inCycle_q + CYCLE_W'(1);
                    state_d   = (inCycle_d == maxCycle_q || earlyDone) ? S_DONE : S_STAGE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_d       = OP_NOP;
        busy_d     = 1'b1;
        finished_d = 1'b0;
        case (state_d)
            S_INIT:    op_d = OP_INIT;
            S_LOAD_RT: op_d = OP_LOAD_RT;
            S_STAGE:   op_d = OP_STAGING;
            S_PH0:     op_d = OP_PHASE0;
            S_PH1:     op_d = OP_PHASE1;
            S_DONE: begin
                busy_d     = 1'b0;
                finished_d = 1'b1;
            end
            default:   busy_d = 1'b0;
        endcase
    end

    // The routing table answers rt_dst within the cycle, so rt_valid and stall gate the registered op late.
    for (genvar i = 0; i < ROUTER_SIZE; i++) begin : g_op
        assign op_o[i*OP_SIZE +: OP_SIZE] =
            ((stall_i && busy_q) || (op_q == OP_LOAD_RT && !rt_valid_i[i])) ? OP_NOP : op_q;
    end

    assign rt_dst_o   = rtDst_q;
    assign in_cycle_o = inCycle_q;
    assign busy_o     = busy_q;
    assign finished_o = finished_q;

endmodule

// File: tb/tb_noc_sequencer.sv
// tb_noc_sequencer: directed and randomized checks of noc_sequencer against a schedule-list model.
// Honours SEQ_DONE_EARLY_EN the same way the design does.
module tb_noc_sequencer;

    localparam int RS  = 4;
    localparam int OPW = 3;

`ifdef SEQ_DONE_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] maxCycle = '0;
    logic [3:0]  rtValid = '0;
    logic [3:0]  routerDone = '0;
    logic [11:0] op;
    logic [1:0]  rtDst;
    logic [15:0] inCycle;
    logic        busy;
    logic        finished;

    int assertCount = 0;
    int failCount   = 0;

    noc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .max_cycle_i  (maxCycle),
        .rt_valid_i   (rtValid),
        .router_done_i(routerDone),
        .stall_i      (stall),
        .op_o         (op),
        .rt_dst_o     (rtDst),
        .in_cycle_o   (inCycle),
        .busy_o       (busy),
        .finished_o   (finished)
    );

    always #5 clk = ~clk;

    // Reference model: the whole run is laid out as a list of slots when start is accepted.
    typedef enum int {K_INIT, K_LOAD, K_STAGE, K_PH0, K_PH1} kind_e;
    typedef struct {
        kind_e kind;
        int    dst;
        int    cyc;
    } slot_t;

    slot_t sched[$];
    int    mPos = 0;
    bit    mRunning = 1'b0;
    bit    mDone = 1'b0;
    int    mDoneCyc = 0;

    function automatic logic [2:0] kindCode(kind_e k);
        case (k)
            K_INIT:  return 3'd1;
            K_LOAD:  return 3'd2;
            K_STAGE: return 3'd3;
            K_PH0:   return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    task automatic pushSlot(kind_e k, int d, int c);
        slot_t s;
        s.kind = k;
        s.dst  = d;
        s.cyc  = c;
        sched.push_back(s);
    endtask

    task automatic modelStart(int m);
        sched.delete();
        pushSlot(K_INIT, 0, 0);
        for (int d = 0; d < RS; d++) pushSlot(K_LOAD, d, 0);
        for (int r = 0; r < m; r++) begin
            pushSlot(K_STAGE, 0, r);
            pushSlot(K_PH0, 0, r);
            pushSlot(K_PH1, 0, r);
        end
        mPos     = 0;
        mRunning = 1'b1;
        mDone    = 1'b0;
        mDoneCyc = m;
    endtask

    task automatic modelReset();
        sched.delete();
        mPos     = 0;
        mRunning = 1'b0;
        mDone    = 1'b0;
        mDoneCyc = 0;
    endtask

    task automatic modelEdge();
        if (!mRunning) begin
            if (start) modelStart(int'(maxCycle));
        end else if (!stall) begin
            if (EARLY && sched[mPos].kind == K_PH1 && routerDone == 4'hF) begin
                mRunning = 1'b0;
                mDone    = 1'b1;
                mDoneCyc = sched[mPos].cyc + 1;
            end else begin
                mPos++;
                if (mPos >= sched.size()) begin
                    mRunning = 1'b0;
                    mDone    = 1'b1;
                end
            end
        end
    endtask

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        logic [11:0] eOp;
        logic [2:0]  code;
        int          eDst, eCyc;
        logic        eBusy, eFin;
        slot_t       s;
        eOp = '0; eDst = 0; eCyc = 0; eBusy = 1'b0; eFin = 1'b0;
        if (mRunning) begin
            s     = sched[mPos];
            eBusy = 1'b1;
            eDst  = s.dst;
            eCyc  = s.cyc;
            code  = stall ? 3'd0 : kindCode(s.kind);
            for (int i = 0; i < RS; i++)
                eOp[i*OPW +: OPW] = (s.kind == K_LOAD && !rtValid[i]) ? 3'd0 : code;
        end else begin
            eFin = mDone;
            eCyc = mDone ? mDoneCyc : 0;
        end
        checkVal({tag, ".op"},       32'(op),       32'(eOp));
        checkVal({tag, ".rtDst"},    32'(rtDst),    32'(eDst));
        checkVal({tag, ".inCycle"},  32'(inCycle),  32'(eCyc));
        checkVal({tag, ".busy"},     32'(busy),     32'(eBusy));
        checkVal({tag, ".finished"}, 32'(finished), 32'(eFin));
    endtask

    task automatic edgeAndSettle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // One run from an idle/done state; optional 2-cycle stall in PH0 and router_done pulse in PH1.
    task automatic applyStimulus(input int m, input logic [3:0] rtv, input int stallRound,
                                 input int doneRound, input int budget, output int busyCycles);
        bit stallUsed = 1'b0;
        int stallLeft = 0;
        bit ended = 1'b0;
        maxCycle   = 16'(m);
        rtValid    = rtv;
        start      = 1'b1;
        stall      = 1'b0;
        routerDone = '0;
        busyCycles = 0;
        for (int n = 0; n < budget; n++) begin
            edgeAndSettle();
            start = 1'b0;
            if (mRunning && !stallUsed && stallRound >= 0 && sched[mPos].kind == K_PH0 &&
                sched[mPos].cyc == stallRound) begin
                stallUsed = 1'b1;
                stallLeft = 2;
            end
            stall = (stallLeft > 0);
            if (stallLeft > 0) stallLeft--;
            routerDone = (mRunning && sched[mPos].kind == K_PH1 && sched[mPos].cyc == doneRound)
                         ? 4'hF : 4'h0;
            @(negedge clk);
            checkOutput("run");
            if (busy === 1'b1) busyCycles++;
            if (!mRunning) begin
                ended = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        routerDone = '0;
        checkVal("runEnds", 32'(ended), 32'(1));
    endtask

    initial begin
        int  busyCycles;
        bit  found;

        #12;
        modelReset();
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] baseline run, max_cycle=2");
        applyStimulus(2, 4'hF, -1, -1, 200, busyCycles);
        checkVal("baseBusyCycles", 32'(busyCycles), 32'(1 + RS + 3 * 2));
        checkVal("baseInCycle", 32'(inCycle), 32'(2));

        $display("[TB] partial routing table 0101");
        applyStimulus(1, 4'b0101, -1, -1, 200, busyCycles);

        $display("[TB] stall two cycles in first PH0");
        applyStimulus(2, 4'hF, 0, -1, 200, busyCycles);
        checkVal("stallBusyCycles", 32'(busyCycles), 32'(1 + RS + 3 * 2 + 2));

        $display("[TB] max_cycle=0");
        applyStimulus(0, 4'hF, -1, -1, 200, busyCycles);
        checkVal("zeroBusyCycles", 32'(busyCycles), 32'(1 + RS));
        checkVal("zeroInCycle", 32'(inCycle), 32'(0));

        $display("[TB] async reset in round 3");
        maxCycle = 16'd5;
        rtValid  = 4'hF;
        start    = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 200; n++) begin
            edgeAndSettle();
            start = 1'b0;
            @(negedge clk);
            checkOutput("preReset");
            if (mRunning && sched[mPos].kind == K_STAGE && sched[mPos].cyc == 2) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("reachRound3", 32'(found), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, 4'hF, -1, -1, 200, busyCycles);
        checkVal("afterResetBusy", 32'(busyCycles), 32'(1 + RS + 3 * 2));

        $display("[TB] router_done in round 4, max_cycle=100");
        applyStimulus(100, 4'hF, -1, 3, 1000, busyCycles);
        checkVal("earlyInCycle", 32'(inCycle), EARLY ? 32'(4) : 32'(100));
        checkVal("earlyBusyCycles", 32'(busyCycles), EARLY ? 32'(1 + RS + 12) : 32'(1 + RS + 300));

        $display("[TB] randomized traffic");
        for (int n = 0; n < 800; n++) begin
            edgeAndSettle();
            start      = ($urandom_range(0, 2) == 0);
            maxCycle   = 16'($urandom_range(0, 3));
            stall      = ($urandom_range(0, 3) == 0);
            rtValid    = 4'($urandom);
            routerDone = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            @(negedge clk);
            checkOutput("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
